// File: rtl/usb11_frame_sched.sv
// Command-stream scheduler for usb11_ctrl: arbitrates host command packets against
// an internally generated 1 ms SOF token stream and tracks response windows.
module usb11_frame_sched #(
  parameter int FRAME_CYCLES = 148000,
  parameter int GUARD_CYCLES = 14800,
  parameter int RSP_TIMEOUT  = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] host_cmd,
  input  logic        host_cmd_valid,
  output logic        host_cmd_ready,
  input  logic        sof_ena,
  input  logic        cmd_full,
  input  logic        rsp_done,
  output logic [15:0] cmd_out,
  output logic        cmd_out_wr,
  output logic [10:0] frame_num,
  output logic        sof_sent,
  output logic        sof_overrun,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int RW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(FRAME_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_START = TW'(FRAME_CYCLES - GUARD_CYCLES);
  localparam logic [RW-1:0] RSP_LAST    = RW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOST_PKT = 2'd1,
    ST_SOF      = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

  // Inverted CRC5 (x^5+x^2+1, seed all-ones, LSB first) packed bit-reversed
  // above the frame number's top three bits, as the token's last byte.
  function automatic logic [7:0] sof_crc_byte(input logic [10:0] fn);
    logic [4:0] crc;
    logic [4:0] c;
    logic       fb;
    crc = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb  = fn[i] ^ crc[4];
      crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    c = ~crc;
    return {c[0], c[1], c[2], c[3], c[4], fn[10:8]};
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    sof_idx_q, sof_idx_d;
  logic [RW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sof_pending_q, sof_pending_d;
  logic          sof_ena_q;
  logic [10:0]   frame_num_q, frame_num_d;
  logic [15:0]   cmd_out_q, cmd_out_d;
  logic          cmd_out_wr_q, cmd_out_wr_d;
  logic          sof_sent_q, sof_sent_d;
  logic          sof_overrun_q, sof_overrun_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic          sof_start_s;
  logic          sof_done_s;
  logic          pkt_ok_s;
  logic          ready_s;
  logic [15:0]   sof_word_s;
  state_e        last_next_s;

  assign sof_start_s = sof_pending_q && sof_ena && !cmd_full;
  assign pkt_ok_s    = !sof_ena || (timer_q < GUARD_START);
  assign last_next_s = host_cmd[12] ? ST_WAIT_RSP : ST_IDLE;

  // SOF word selected by position within the token sequence
  always_comb begin
    sof_word_s = 16'hC080;
    case (sof_idx_q)
      2'd0:    sof_word_s = 16'hC080;
      2'd1:    sof_word_s = 16'h40A5;
      2'd2:    sof_word_s = {8'h40, frame_num_q[7:0]};
      2'd3:    sof_word_s = {8'h60, sof_crc_byte(frame_num_q)};
      default: sof_word_s = 16'hC080;
    endcase
  end

  // Scheduler next-state and output-word selection
  always_comb begin
    state_d       = state_q;
    sof_idx_d     = sof_idx_q;
    rsp_cnt_d     = {RW{1'b0}};
    frame_num_d   = frame_num_q;
    cmd_out_d     = cmd_out_q;
    cmd_out_wr_d  = 1'b0;
    sof_sent_d    = 1'b0;
    rsp_timeout_d = 1'b0;
    sof_done_s    = 1'b0;
    ready_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sof_start_s) begin
          cmd_out_d    = 16'hC080;
          cmd_out_wr_d = 1'b1;
          sof_idx_d    = 2'd1;
          state_d      = ST_SOF;
        end else if (cmd_full || (sof_pending_q && sof_ena)) begin
          ready_s = 1'b0;
        end else if (host_cmd[15:14] == 2'b00) begin
          ready_s = 1'b1;
          if (host_cmd_valid) begin
            cmd_out_d    = host_cmd;
            cmd_out_wr_d = 1'b1;
          end else begin
            cmd_out_wr_d = 1'b0;
          end
        end else if (host_cmd[15]) begin
          ready_s = pkt_ok_s;
          if (host_cmd_valid && pkt_ok_s) begin
            cmd_out_d    = host_cmd;
            cmd_out_wr_d = 1'b1;
            state_d      = host_cmd[13] ? last_next_s : ST_HOST_PKT;
          end else begin
            cmd_out_wr_d = 1'b0;
          end
        end else begin
          // A continuation word with no open packet is drained, not forwarded.
          ready_s = 1'b1;
        end
      end
      ST_HOST_PKT: begin
        ready_s = !cmd_full;
        if (host_cmd_valid && !cmd_full) begin
          cmd_out_d    = host_cmd;
          cmd_out_wr_d = 1'b1;
          state_d      = host_cmd[13] ? last_next_s : ST_HOST_PKT;
        end else begin
          cmd_out_wr_d = 1'b0;
        end
      end
      ST_SOF: begin
        if (!cmd_full) begin
          cmd_out_d    = sof_word_s;
          cmd_out_wr_d = 1'b1;
          if (sof_idx_q == 2'd3) begin
            sof_sent_d  = 1'b1;
            sof_done_s  = 1'b1;
            frame_num_d = frame_num_q + 11'd1;
            sof_idx_d   = 2'd0;
            state_d     = ST_IDLE;
          end else begin
            sof_idx_d = sof_idx_q + 2'd1;
          end
        end else begin
          cmd_out_wr_d = 1'b0;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end else if (rsp_cnt_q == RSP_LAST) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          rsp_cnt_d = rsp_cnt_q + {{(RW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame timer and SOF pending flag; a tick landing during a finishing SOF re-arms it
  always_comb begin
    timer_d       = timer_q;
    sof_pending_d = sof_pending_q;
    sof_overrun_d = 1'b0;
    if (!sof_ena) begin
      timer_d       = {TW{1'b0}};
      sof_pending_d = 1'b0;
    end else if (!sof_ena_q) begin
      timer_d       = {TW{1'b0}};
      sof_pending_d = 1'b1;
    end else if (timer_q == TIMER_LAST) begin
      timer_d       = {TW{1'b0}};
      sof_pending_d = 1'b1;
      sof_overrun_d = sof_pending_q && !sof_done_s;
    end else begin
      timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
      if (sof_done_s) begin
        sof_pending_d = 1'b0;
      end else begin
        sof_pending_d = sof_pending_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sof_idx_q     <= 2'd0;
      rsp_cnt_q     <= {RW{1'b0}};
      timer_q       <= {TW{1'b0}};
      sof_pending_q <= 1'b0;
      sof_ena_q     <= 1'b0;
      frame_num_q   <= 11'd0;
      cmd_out_q     <= 16'h0000;
      cmd_out_wr_q  <= 1'b0;
      sof_sent_q    <= 1'b0;
      sof_overrun_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sof_idx_q     <= sof_idx_d;
      rsp_cnt_q     <= rsp_cnt_d;
      timer_q       <= timer_d;
      sof_pending_q <= sof_pending_d;
      sof_ena_q     <= sof_ena;
      frame_num_q   <= frame_num_d;
      cmd_out_q     <= cmd_out_d;
      cmd_out_wr_q  <= cmd_out_wr_d;
      sof_sent_q    <= sof_sent_d;
      sof_overrun_q <= sof_overrun_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign host_cmd_ready = ready_s & ~reset;
  assign cmd_out        = cmd_out_q;
  assign cmd_out_wr     = cmd_out_wr_q;
  assign frame_num      = frame_num_q;
  assign sof_sent       = sof_sent_q;
  assign sof_overrun    = sof_overrun_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb11_frame_sched.sv
// Directed bench for usb11_frame_sched with shortened frame/guard/timeout lengths.
module tb_usb11_frame_sched;

  localparam int FC = 24;
  localparam int GC = 6;
  localparam int RT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] host_cmd = 16'h0000;
  logic        host_cmd_valid = 1'b0;
  logic        host_cmd_ready;
  logic        sof_ena = 1'b0;
  logic        cmd_full = 1'b0;
  logic        rsp_done = 1'b0;
  logic [15:0] cmd_out;
  logic        cmd_out_wr;
  logic [10:0] frame_num;
  logic        sof_sent;
  logic        sof_overrun;
  logic        rsp_timeout;
  logic        busy;

  usb11_frame_sched #(.FRAME_CYCLES(FC), .GUARD_CYCLES(GC), .RSP_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_cmd_valid(host_cmd_valid),
    .host_cmd_ready(host_cmd_ready), .sof_ena(sof_ena), .cmd_full(cmd_full),
    .rsp_done(rsp_done), .cmd_out(cmd_out), .cmd_out_wr(cmd_out_wr),
    .frame_num(frame_num), .sof_sent(sof_sent), .sof_overrun(sof_overrun),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wq[$];
  int          wt[$];
  int          to_n = 0, to_cyc = -1, ov_n = 0, ov_cyc = -1, ss_cyc = -1;

  // Write/pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (cmd_out_wr) begin
      wq.push_back(cmd_out);
      wt.push_back(cyc);
    end
    if (rsp_timeout) begin
      to_n++;
      to_cyc = cyc;
    end
    if (sof_overrun) begin
      ov_n++;
      ov_cyc = cyc;
    end
    if (sof_sent) ss_cyc = cyc;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qclr();
    wq.delete();
    wt.delete();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_q(input int n, input int limit, input string tag);
    int k = 0;
    while (wq.size() < n && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(wq.size() >= n), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input string tag);
    int k = 0;
    host_cmd = w;
    host_cmd_valid = 1'b1;
    #1;
    while (!host_cmd_ready && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(host_cmd_ready), 32'd1);
    @(negedge clk);
    host_cmd_valid = 1'b0;
  endtask

  int k2, kk, j0, a, tob, g;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_out", 32'(cmd_out), 32'h0);
    chk("rst_wr", 32'(cmd_out_wr), 32'h0);
    chk("rst_frame", 32'(frame_num), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(host_cmd_ready), 32'h0);

    // First SOF right after enable, then the next one a frame later
    @(negedge clk);
    qclr();
    sof_ena = 1'b1;
    reset = 1'b0;
    j0 = cyc;
    wait_q(4, 20, "sof0_seen");
    chk("sof0_lat", 32'(wt[0]), 32'(j0 + 2));
    chk("sof0_w0", 32'(wq[0]), 32'hC080);
    chk("sof0_w1", 32'(wq[1]), 32'h40A5);
    chk("sof0_w2", 32'(wq[2]), 32'h4000);
    chk("sof0_w3", 32'(wq[3]), 32'h6010);
    chk("sof0_contig", 32'(wt[3] - wt[0]), 32'd3);
    chk("sof0_sent", 32'(ss_cyc), 32'(wt[3]));
    chk("sof0_frame", 32'(frame_num), 32'd1);
    wait_q(8, 40, "sof1_seen");
    chk("sof1_period", 32'(wt[4] - wt[0]), 32'(FC));
    chk("sof1_w2", 32'(wq[6]), 32'h4001);
    chk("sof1_w3", 32'(wq[7]), 32'h60E8);
    k2 = wt[4];

    // Host packet straddling a frame tick stays contiguous, SOF follows
    wait_cyc(k2 + 15);
    qclr();
    send_word(16'hC080, "pkt_w0");
    send_word(16'h402D, "pkt_w1");
    repeat (10) @(negedge clk);
    send_word(16'h4000, "pkt_w2");
    send_word(16'h6010, "pkt_w3");
    wait_q(8, 30, "pkt_sof_seen");
    chk("pkt_q0", 32'(wq[0]), 32'hC080);
    chk("pkt_q1", 32'(wq[1]), 32'h402D);
    chk("pkt_q2", 32'(wq[2]), 32'h4000);
    chk("pkt_q3", 32'(wq[3]), 32'h6010);
    chk("pkt_sof_w0", 32'(wq[4]), 32'hC080);
    chk("pkt_sof_w1", 32'(wq[5]), 32'h40A5);
    chk("pkt_sof_w2", 32'(wq[6]), 32'h4002);
    chk("pkt_sof_after", 32'(wt[4] - wt[3]), 32'd1);
    chk("pkt_no_ovr", 32'(ov_n), 32'd0);

    // Response-expecting packet released by rsp_done
    sof_ena = 1'b0;
    repeat (2) @(negedge clk);
    qclr();
    send_word(16'hC080, "rsp_w0");
    send_word(16'h4069, "rsp_w1");
    send_word(16'h4000, "rsp_w2");
    send_word(16'h7010, "rsp_w3");
    host_cmd = 16'h0402;
    host_cmd_valid = 1'b1;
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_ready", 32'(host_cmd_ready), 32'd0);
    repeat (18) @(negedge clk);
    host_cmd_valid = 1'b0;
    rsp_done = 1'b1;
    @(negedge clk);
    rsp_done = 1'b0;
    #1;
    chk("rsp_idle", 32'(busy), 32'd0);
    chk("rsp_no_to", 32'(to_n), 32'd0);
    chk("rsp_no_leak", 32'(wq.size()), 32'd4);

    // Same packet without a response: timeout after RT cycles
    send_word(16'hC080, "to_w0");
    send_word(16'h4069, "to_w1");
    send_word(16'h4000, "to_w2");
    send_word(16'h7010, "to_w3");
    a = cyc;
    g = 0;
    while (to_n == 0 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("to_cyc", 32'(to_cyc), 32'(a + RT));
    chk("to_idle", 32'(busy), 32'd0);

    // rsp_done coinciding with the last count suppresses the timeout
    send_word(16'hC080, "tie_w0");
    send_word(16'h4069, "tie_w1");
    send_word(16'h4000, "tie_w2");
    send_word(16'h7010, "tie_w3");
    a = cyc;
    tob = to_n;
    wait_cyc(a + RT - 1);
    rsp_done = 1'b1;
    @(negedge clk);
    rsp_done = 1'b0;
    #1;
    chk("tie_no_to", 32'(to_n), 32'(tob));
    chk("tie_idle", 32'(busy), 32'd0);

    // Guard window: control word passes, packet-first held until after the SOF
    @(negedge clk);
    qclr();
    sof_ena = 1'b1;
    j0 = cyc;
    wait_q(4, 20, "g_sof_seen");
    chk("g_sof_lat", 32'(wt[0]), 32'(j0 + 2));
    chk("g_sof_w2", 32'(wq[2]), 32'h4003);
    kk = wt[0];
    wait_cyc(kk + 18);
    qclr();
    host_cmd = 16'h0402;
    host_cmd_valid = 1'b1;
    #1;
    chk("g_ctrl_ready", 32'(host_cmd_ready), 32'd1);
    @(negedge clk);
    host_cmd = 16'hC080;
    #1;
    chk("g_pkt_blocked", 32'(host_cmd_ready), 32'd0);
    g = 0;
    while (!host_cmd_ready && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("g_release_cyc", 32'(cyc), 32'(kk + 27));
    @(negedge clk);
    send_word(16'h6010, "g_pkt_last");
    #1;
    chk("g_q_size", 32'(wq.size()), 32'd7);
    chk("g_ctrl", 32'(wq[0]), 32'h0402);
    chk("g_ctrl_t", 32'(wt[0]), 32'(kk + 19));
    chk("g_sof_first", 32'(wq[1]), 32'hC080);
    chk("g_sof_w2b", 32'(wq[3]), 32'h4004);
    chk("g_host_after", 32'(wq[5]), 32'hC080);
    chk("g_host_t", 32'(wt[5]), 32'(kk + 28));

    // cmd_full stalls an SOF mid-sequence
    wait_cyc(kk + 40);
    qclr();
    wait_cyc(kk + 49);
    cmd_full = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("full_hold_val", 32'(cmd_out), 32'h40A5);
    chk("full_hold_wr", 32'(cmd_out_wr), 32'd0);
    repeat (5) @(negedge clk);
    cmd_full = 1'b0;
    wait_q(4, 20, "full_seen");
    repeat (2) @(negedge clk);
    #1;
    chk("full_size", 32'(wq.size()), 32'd4);
    chk("full_w0", 32'(wq[0]), 32'hC080);
    chk("full_w1", 32'(wq[1]), 32'h40A5);
    chk("full_w2", 32'(wq[2]), 32'h4005);
    chk("full_w3_hi", 32'(wq[3] >> 8), 32'h60);
    chk("full_gap", 32'(wt[2] - wt[1]), 32'd11);

    // SOF still pending at the next tick raises overrun
    wait_cyc(kk + 64);
    qclr();
    wait_cyc(kk + 65);
    cmd_full = 1'b1;
    wait_cyc(kk + 100);
    cmd_full = 1'b0;
    chk("ovr_count", 32'(ov_n), 32'd1);
    chk("ovr_cyc", 32'(ov_cyc), 32'(kk + 95));
    wait_q(4, 20, "ovr_sof_seen");
    chk("ovr_sof_w2", 32'(wq[2]), 32'h4006);
    chk("ovr_sof_t", 32'(wt[0]), 32'(kk + 101));

    // Asynchronous reset in the middle of a host packet
    wait_cyc(kk + 105);
    send_word(16'hC080, "rst_pkt_w0");
    #1;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_cmd_out", 32'(cmd_out), 32'h0);
    chk("arst_wr", 32'(cmd_out_wr), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_frame", 32'(frame_num), 32'h0);
    chk("arst_ready", 32'(host_cmd_ready), 32'h0);
    qclr();
    repeat (3) @(negedge clk);
    #1;
    chk("arst_no_writes", 32'(wq.size()), 32'd0);

    // Free-run to frame 2047 and across the wrap to frame 0
    @(negedge clk);
    reset = 1'b0;
    g = 0;
    while (frame_num != 11'd2047 && g < 52000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("wrap_reach", 32'(frame_num), 32'd2047);
    @(negedge clk);
    #1;
    qclr();
    wait_q(8, 60, "wrap_seen");
    chk("wrap_w2", 32'(wq[2]), 32'h40FF);
    chk("wrap_w3", 32'(wq[3]), 32'h6047);
    chk("wrap0_w2", 32'(wq[6]), 32'h4000);
    chk("wrap0_w3", 32'(wq[7]), 32'h6010);
    chk("wrap_period", 32'(wt[4] - wt[0]), 32'(FC));
    chk("wrap_frame", 32'(frame_num), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
